// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the HI/LO multiply/divide unit.
// The core drives op launch and MTHI/MTLO; the unit returns status and HI/LO.
`timescale 1ns/1ps
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_wen;
  logic             lo_wen;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    output hi_wen, lo_wen, wdata,
    input  busy, done, div_by_zero,
    input  hi, lo
  );

  modport slave (
    input  start, op, a, b,
    input  hi_wen, lo_wen, wdata,
    output busy, done, div_by_zero,
    output hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU with architectural HI/LO.
// One shift-add / restoring step per cycle, then one sign-fix cycle.
`timescale 1ns/1ps
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int W2    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             r_done;
  logic             r_dz_out;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_a_raw;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [W2-1:0]    r_prod;

  logic             w_idle;
  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_trial;
  logic [W2-1:0]    w_mul_nx;
  logic [W2-1:0]    w_div_nx;
  logic [W2-1:0]    w_prod_neg;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle & bus.start;

  assign w_a_neg = bus.op[0] & bus.a[WIDTH-1];
  assign w_b_neg = bus.op[0] & bus.b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -bus.a : bus.a;
  assign w_b_mag = w_b_neg ? -bus.b : bus.b;

  // Multiply: add multiplicand into the upper half, shift right.
  assign w_msum = {1'b0, r_prod[W2-1:WIDTH]}
                + ({(WIDTH+1){r_prod[0]}}
                & {1'b0, r_opnd});
  assign w_mul_nx = {w_msum, r_prod[WIDTH-1:1]};

  // Divide: {rem, quo} shifts left; the trial uses rem plus next bit.
  assign w_trial  = r_prod[W2-1:WIDTH-1] - {1'b0, r_opnd};
  assign w_div_nx = w_trial[WIDTH]
                  ? {r_prod[W2-2:0], 1'b0}
                  : {w_trial[WIDTH-1:0],
                     r_prod[WIDTH-2:0], 1'b1};

  assign w_prod_neg = -r_prod;
  assign w_q = r_prod[WIDTH-1:0];
  assign w_r = r_prod[W2-1:WIDTH];

  always_comb begin
    w_fix_hi = r_prod[W2-1:WIDTH];
    w_fix_lo = r_prod[WIDTH-1:0];
    unique case (1'b1)
      r_dz: begin
        w_fix_hi = r_a_raw;
        w_fix_lo = '1;
      end
      (r_is_div & ~r_dz): begin
        w_fix_hi = r_neg_r ? -w_r : w_r;
        w_fix_lo = r_neg_q ? -w_q : w_q;
      end
      (~r_is_div): begin
        if (r_neg_q) begin
          w_fix_hi = w_prod_neg[W2-1:WIDTH];
          w_fix_lo = w_prod_neg[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.start) w_next = S_CALC;
      S_CALC: if (r_cnt == CNT_W'(1)) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_dz_out <= 1'b0;
      r_opnd   <= '0;
      r_a_raw  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_prod   <= '0;
    end else begin
      r_done   <= (r_state == S_FIX);
      r_dz_out <= (r_state == S_FIX) & r_dz;
      if (w_accept) begin
        r_cnt    <= CNT_W'(WIDTH);
        r_is_div <= bus.op[1];
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_dz     <= bus.op[1] & (bus.b == '0);
        r_a_raw  <= bus.a;
        r_opnd   <= bus.op[1] ? w_b_mag : w_a_mag;
        r_prod   <= bus.op[1]
                  ? {{WIDTH{1'b0}}, w_a_mag}
                  : {{WIDTH{1'b0}}, w_b_mag};
      end else if (r_state == S_CALC) begin
        r_cnt  <= r_cnt - CNT_W'(1);
        r_prod <= r_is_div ? w_div_nx : w_mul_nx;
      end
      if (r_state == S_FIX) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else if (w_idle & ~bus.start) begin
        if (bus.hi_wen) r_hi <= bus.wdata;
        if (bus.lo_wen) r_lo <= bus.wdata;
      end
    end
  end

  assign bus.busy        = ~w_idle;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dz_out;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule
